// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - requesting end of the ALU_4bit operand/command interface
//
// Purpose: accepts ALU operations on a valid/ready request port, drives the
// registered operands/command into an external combinational ALU, holds them
// for SETTLE_CYCLES edges, then samples result and flags into a valid/ready
// response port.
//
// Optional feature macro: ALU_RESULT_CHECK_EN (result self-check and
// saturating mismatch tally). Undefined: req_expect ignored, rsp_mismatch and
// mismatch_count tied to 0.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_command, req_a, req_b         ALU command and operands
//   req_expect                        expected {result,carryout,zero,overflow}
//   alu_a, alu_b, alu_command         registered ALU inputs
//   alu_result, alu_carryout,
//   alu_zero, alu_overflow            ALU outputs
//   rsp_valid/rsp_ready               response handshake
//   rsp_command, rsp_result,
//   rsp_carryout, rsp_zero,
//   rsp_overflow                      sampled response
//   rsp_mismatch, mismatch_count      check result and saturating tally
//   busy                              issuer not idle
module alu_op_issuer #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_command,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [WIDTH+2:0]   req_expect,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_command,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carryout,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_command,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carryout,
  output logic               rsp_zero,
  output logic               rsp_overflow,
  output logic               rsp_mismatch,
  output logic [CNT_W-1:0]   mismatch_count,
  output logic               busy
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [2:0]         r_alu_command;
  logic               r_rsp_valid;
  logic [2:0]         r_rsp_command;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_carryout;
  logic               r_rsp_zero;
  logic               r_rsp_overflow;

  logic               w_accept;
  logic [WIDTH+2:0]   w_sample;

`ifdef ALU_RESULT_CHECK_EN
  logic [WIDTH+2:0]   r_expect;
  logic               r_mismatch;
  logic [CNT_W-1:0]   r_mcount;
  logic               w_mismatch;

  assign w_mismatch = (w_sample != r_expect);
`else
  logic               w_unused_expect;

  assign w_unused_expect = ^req_expect;
`endif

  // Ready is forced low while reset is asserted; in RESP a new request can
  // only enter on the same edge the pending response is consumed.
  assign req_ready = reset_n & ((r_state == IDLE) | ((r_state == RESP) & rsp_ready));
  assign w_accept  = req_valid & req_ready;
  assign w_sample  = {alu_result, alu_carryout, alu_zero, alu_overflow};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_command  <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_command  <= '0;
      r_rsp_result   <= '0;
      r_rsp_carryout <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
`ifdef ALU_RESULT_CHECK_EN
      r_expect       <= '0;
      r_mismatch     <= 1'b0;
      r_mcount       <= '0;
`endif
    end else begin
      // Accept can only happen in IDLE or RESP, so this never collides with
      // the SETTLE countdown below.
      if (w_accept) begin
        r_alu_a       <= req_a;
        r_alu_b       <= req_b;
        r_alu_command <= req_command;
        r_cnt         <= CNT_LOAD;
`ifdef ALU_RESULT_CHECK_EN
        r_expect      <= req_expect;
`endif
      end

      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= SETTLE;
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_command  <= r_alu_command;
            r_rsp_result   <= alu_result;
            r_rsp_carryout <= alu_carryout;
            r_rsp_zero     <= alu_zero;
            r_rsp_overflow <= alu_overflow;
`ifdef ALU_RESULT_CHECK_EN
            r_mismatch     <= w_mismatch;
            if (w_mismatch && (r_mcount != {CNT_W{1'b1}})) r_mcount <= r_mcount + 1'b1;
`endif
            r_state        <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= req_valid ? SETTLE : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_command  = r_alu_command;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_command  = r_rsp_command;
  assign rsp_result   = r_rsp_result;
  assign rsp_carryout = r_rsp_carryout;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_overflow;
  assign busy         = (r_state != IDLE);

`ifdef ALU_RESULT_CHECK_EN
  assign rsp_mismatch   = r_mismatch;
  assign mismatch_count = r_mcount;
`else
  assign rsp_mismatch   = 1'b0;
  assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - scoreboard bench for alu_op_issuer with an ALU_4bit model
module tb_alu_op_issuer;

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_XOR = 3'd2, C_SLT = 3'd3,
                         C_AND = 3'd4, C_NAND = 3'd5, C_NOR = 3'd6, C_OR = 3'd7;
`ifdef ALU_RESULT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (SETTLE_CYCLES = 8)
  logic       reset_n, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0] req_command, alu_command, rsp_command;
  logic [3:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [6:0] req_expect;
  logic       alu_carryout, alu_zero, alu_overflow;
  logic       rsp_carryout, rsp_zero, rsp_overflow, rsp_mismatch, busy;
  logic [7:0] mismatch_count;

  // Second DUT (SETTLE_CYCLES = 1)
  logic       s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic [2:0] s_req_command, s_alu_command, s_rsp_command;
  logic [3:0] s_req_a, s_req_b, s_alu_a, s_alu_b, s_alu_result, s_rsp_result;
  logic [6:0] s_req_expect;
  logic       s_alu_carryout, s_alu_zero, s_alu_overflow;
  logic       s_rsp_carryout, s_rsp_zero, s_rsp_overflow, s_rsp_mismatch, s_busy;
  logic [7:0] s_mismatch_count;

  // ALU_4bit behavioural model: returns {result, carryout, zero, overflow}
  function automatic logic [6:0] alu_model(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       co, ov;
    s = 5'd0; r = 4'd0; co = 1'b0; ov = 1'b0;
    case (c)
      C_ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; co = s[4]; ov = (a[3] == b[3]) && (s[3] != a[3]); end
      C_SUB:  begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; co = s[4]; ov = (a[3] != b[3]) && (s[3] != a[3]); end
      C_XOR:  r = a ^ b;
      C_SLT:  r = {3'b000, ($signed(a) < $signed(b))};
      C_AND:  r = a & b;
      C_NAND: r = ~(a & b);
      C_NOR:  r = ~(a | b);
      default: r = a | b;
    endcase
    return {r, co, (r == 4'd0), ov};
  endfunction

  assign {alu_result, alu_carryout, alu_zero, alu_overflow} = alu_model(alu_command, alu_a, alu_b);
  assign {s_alu_result, s_alu_carryout, s_alu_zero, s_alu_overflow} = alu_model(s_alu_command, s_alu_a, s_alu_b);

  alu_op_issuer #(.WIDTH(4), .SETTLE_CYCLES(8), .CNT_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_command(req_command), .req_a(req_a), .req_b(req_b), .req_expect(req_expect),
    .alu_a(alu_a), .alu_b(alu_b), .alu_command(alu_command), .alu_result(alu_result),
    .alu_carryout(alu_carryout), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_command(rsp_command),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_mismatch(rsp_mismatch),
    .mismatch_count(mismatch_count), .busy(busy)
  );

  alu_op_issuer #(.WIDTH(4), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_command(s_req_command), .req_a(s_req_a), .req_b(s_req_b), .req_expect(s_req_expect),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_command(s_alu_command), .alu_result(s_alu_result),
    .alu_carryout(s_alu_carryout), .alu_zero(s_alu_zero), .alu_overflow(s_alu_overflow),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_command(s_rsp_command),
    .rsp_result(s_rsp_result), .rsp_carryout(s_rsp_carryout), .rsp_zero(s_rsp_zero),
    .rsp_overflow(s_rsp_overflow), .rsp_mismatch(s_rsp_mismatch),
    .mismatch_count(s_mismatch_count), .busy(s_busy)
  );

  typedef struct {
    logic [2:0] cmd;
    logic [6:0] tuple;
    logic       mism;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_response", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_command", 32'(rsp_command), 32'(e.cmd));
          chk("rsp_result_flags", 32'({rsp_result, rsp_carryout, rsp_zero, rsp_overflow}), 32'(e.tuple));
          chk("rsp_mismatch", 32'(rsp_mismatch), 32'(CHK_EN ? e.mism : 1'b0));
        end
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b,
                      input logic [6:0] expv, input logic [6:0] tuple, input logic mism, input bit push);
    int w;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_command = c; req_a = a; req_b = b; req_expect = expv;
    if (push) begin
      e.cmd = c; e.tuple = tuple; e.mism = mism;
      sb_q.push_back(e);
    end
    w = 0;
    #1;
    while (!req_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (w >= 50) chk("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called right after the accept edge; counts edges until rsp_valid rises.
  task automatic wait_rsp(input int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_latency", 32'(n), 32'(lat));
  endtask

  task automatic pop();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_command = 3'd0; req_a = 4'd0; req_b = 4'd0; req_expect = 7'd0;
    s_req_valid = 1'b0; s_rsp_ready = 1'b0;
    s_req_command = 3'd0; s_req_a = 4'd0; s_req_b = 4'd0; s_req_expect = 7'd0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_alu_a", 32'(alu_a), 32'd0);
    chk("reset_count", 32'(mismatch_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    // ADD 1111+1111 -> 1110, carry 1, overflow 0
    send(C_ADD, 4'b1111, 4'b1111, 7'b1110_1_0_0, 7'b1110_1_0_0, 1'b0, 1'b1);
    chk("busy_settle", 32'(busy), 32'd1);
    wait_rsp(8);
    pop();

    // SUB 1111-1111 -> 0000, zero 1, held for 5 cycles
    send(C_SUB, 4'b1111, 4'b1111, 7'b0000_1_1_0, 7'b0000_1_1_0, 1'b0, 1'b1);
    wait_rsp(8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_result", 32'(rsp_result), 32'd0);
      chk("hold_rsp_zero", 32'(rsp_zero), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end

    // Back-to-back: pop SUB and accept SLT 0001<0011 on the same edge
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_command = C_SLT; req_a = 4'b0001; req_b = 4'b0011; req_expect = 7'b0001_0_0_0;
    sb_q.push_back('{cmd: C_SLT, tuple: 7'b0001_0_0_0, mism: 1'b0});
    #1;
    chk("b2b_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("b2b_rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_alu_command", 32'(alu_command), 32'(C_SLT));
    wait_rsp(8);
    pop();

    // Further directed vectors
    send(C_XOR, 4'b0101, 4'b0011, 7'b0110_0_0_0, 7'b0110_0_0_0, 1'b0, 1'b1);
    wait_rsp(8); pop();
    send(C_OR, 4'b1000, 4'b0001, 7'b1001_0_0_0, 7'b1001_0_0_0, 1'b0, 1'b1);
    wait_rsp(8); pop();
    send(C_ADD, 4'b0111, 4'b0001, 7'b1000_0_0_1, 7'b1000_0_0_1, 1'b0, 1'b1);
    wait_rsp(8); pop();

    // Check feature: NAND 1010,1100 = 0111
    send(C_NAND, 4'b1010, 4'b1100, 7'b0111_0_0_0, 7'b0111_0_0_0, 1'b0, 1'b1);
    wait_rsp(8); pop();
    chk("count_after_match", 32'(mismatch_count), 32'd0);
    send(C_NAND, 4'b1010, 4'b1100, 7'b0000_0_0_0, 7'b0111_0_0_0, 1'b1, 1'b1);
    wait_rsp(8); pop();
    chk("count_after_mismatch", 32'(mismatch_count), CHK_EN ? 32'd1 : 32'd0);
`ifdef ALU_RESULT_CHECK_EN
    for (int i = 0; i < 299; i++) begin
      send(C_NAND, 4'b1010, 4'b1100, 7'b0000_0_0_0, 7'b0111_0_0_0, 1'b1, 1'b1);
      wait_rsp(8); pop();
    end
    chk("count_saturated", 32'(mismatch_count), 32'd255);
`endif

    // Reset mid-SETTLE aborts the op with no response
    send(C_AND, 4'b0101, 4'b0110, 7'd0, 7'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    chk("midrst_alu_cmd", 32'(alu_command), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_count", 32'(mismatch_count), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_release_ready", 32'(req_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (rsp_valid || busy) seen++;
      end
      chk("midrst_no_response", 32'(seen), 32'd0);
    end

    // SETTLE_CYCLES=1 instance: ADD 0001+0010 -> 0011 one edge after accept
    @(negedge clk);
    s_req_valid = 1'b1; s_req_command = C_ADD; s_req_a = 4'b0001; s_req_b = 4'b0010;
    #1;
    chk("s1_req_ready", 32'(s_req_ready), 32'd1);
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    chk("s1_rsp_valid_accept_edge", 32'(s_rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("s1_rsp_valid", 32'(s_rsp_valid), 32'd1);
    chk("s1_rsp_result", 32'({s_rsp_result, s_rsp_carryout, s_rsp_zero, s_rsp_overflow}), 32'(7'b0011_0_0_0));
    @(negedge clk);
    s_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    s_rsp_ready = 1'b0;
    chk("s1_rsp_drop", 32'(s_rsp_valid), 32'd0);
    chk("s1_idle", 32'(s_busy), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
